// File: rtl/bullcow_pkg.sv
// bullcow_pkg: shared state encoding, winner codes and score-width helper for the Bulls-and-Cows engine.
package bullcow_pkg;
    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } state_t;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_J1   = 2'b01;
    localparam logic [1:0] WIN_J2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    function automatic int count_w(input int digits);
        return $clog2(digits + 1);
    endfunction
endpackage

// File: rtl/bullcow_scorer.sv
// bullcow_scorer: combinational bulls/cows count with one-to-one cow matching.
module bullcow_scorer
    import bullcow_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int CW      = count_w(DIGITS)
) (
    input  logic [DIGITS*DIGIT_W-1:0] guess,
    input  logic [DIGITS*DIGIT_W-1:0] secret,
    output logic [CW-1:0]             bulls,
    output logic [CW-1:0]             cows
);
    logic [DIGITS-1:0] bull;
    logic [DIGITS-1:0] used;
    logic              found;
    // Each secret position is consumed at most once, by a bull or by the first unmatched cow.
    always_comb begin
        bulls = '0;
        cows  = '0;
        found = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bull[i] = guess[i*DIGIT_W +: DIGIT_W] == secret[i*DIGIT_W +: DIGIT_W];
            if (bull[i]) bulls = bulls + CW'(1);
        end
        used = bull;
        for (int i = 0; i < DIGITS; i++) begin
            found = 1'b0;
            if (!bull[i]) begin
                for (int j = 0; j < DIGITS; j++) begin
                    if (!found && !used[j] && guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W]) begin
                        used[j] = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
            if (found) cows = cows + CW'(1);
        end
    end
endmodule

// File: rtl/bullcow_engine.sv
// bullcow_engine: two-player Bulls-and-Cows game FSM with round limit, draw detection and saturating scores.
// BULLCOW_REPEAT_DIGITS_EN allows repeated digits in secrets and guesses.
module bullcow_engine
    import bullcow_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int BASE       = 10,
    parameter int MAX_ROUNDS = 10,
    parameter int CW         = count_w(DIGITS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enter,
    input  logic [DIGITS*DIGIT_W-1:0] SW,
    output logic [2:0]                game_state,
    output logic [CW-1:0]             bull_count,
    output logic [CW-1:0]             cow_count,
    output logic                      result_valid,
    output logic                      input_error,
    output logic [7:0]                round,
    output logic [1:0]                winner,
    output logic [7:0]                J1_points,
    output logic [7:0]                J2_points
);
    localparam int NW = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W:0] BASE_L = BASE[DIGIT_W:0];
    localparam logic [7:0]       MAXR_L = MAX_ROUNDS[7:0];
    localparam logic [CW-1:0]    FULL_L = DIGITS[CW-1:0];

    state_t          state, next;
    logic            prev_enter;
    logic [NW-1:0]   secret1, secret2;
    logic [CW-1:0]   bulls, cows;
    logic            valid, press, acc, full, last;
    logic            ld_s1, ld_s2, scoring, win_j1, win_j2, draw, bump, clear, err;

    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, SW[i*DIGIT_W +: DIGIT_W]} >= BASE_L) valid = 1'b0;
`ifndef BULLCOW_REPEAT_DIGITS_EN
            for (int j = i + 1; j < DIGITS; j++)
                if (SW[i*DIGIT_W +: DIGIT_W] == SW[j*DIGIT_W +: DIGIT_W]) valid = 1'b0;
`endif
        end
    end

    bullcow_scorer #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .CW(CW)) u_scorer (
        .guess  (SW),
        .secret (state == J2_GUESS ? secret1 : secret2),
        .bulls  (bulls),
        .cows   (cows)
    );

    assign press      = enter && !prev_enter;
    assign acc        = press && valid;
    assign full       = bulls == FULL_L;
    assign last       = round == MAXR_L;
    assign game_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= J1_SETUP;
        else          state <= next;
    end

    always_comb begin
        next = J1_SETUP;
        case (state)
            J1_SETUP: next = acc ? J2_SETUP : J1_SETUP;
            J2_SETUP: next = acc ? J1_GUESS : J2_SETUP;
            J1_GUESS: next = !acc ? J1_GUESS : full ? END_GAME : J2_GUESS;
            J2_GUESS: next = !acc ? J2_GUESS : (full || last) ? END_GAME : J1_GUESS;
            END_GAME: next = press ? J1_SETUP : END_GAME;
            default:  next = J1_SETUP;
        endcase
    end

    // Win is judged on the freshly scored bulls, so it outranks the draw on the last J2 guess.
    always_comb begin
        ld_s1   = acc && state == J1_SETUP;
        ld_s2   = acc && state == J2_SETUP;
        scoring = acc && (state == J1_GUESS || state == J2_GUESS);
        win_j1  = scoring && full && state == J1_GUESS;
        win_j2  = scoring && full && state == J2_GUESS;
        draw    = scoring && !full && state == J2_GUESS && last;
        bump    = scoring && !full && state == J2_GUESS && !last;
        clear   = press && state == END_GAME;
        err     = press && !valid && state inside {J1_SETUP, J2_SETUP, J1_GUESS, J2_GUESS};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_enter   <= 1'b0;
            secret1      <= '0;
            secret2      <= '0;
            bull_count   <= '0;
            cow_count    <= '0;
            result_valid <= 1'b0;
            input_error  <= 1'b0;
            round        <= '0;
            winner       <= WIN_NONE;
            J1_points    <= '0;
            J2_points    <= '0;
        end else begin
            prev_enter   <= enter;
            result_valid <= scoring;
            input_error  <= err;
            if (ld_s1) secret1 <= SW;
            if (ld_s2) begin
                secret2 <= SW;
                round   <= 8'd1;
            end
            if (scoring) begin
                bull_count <= bulls;
                cow_count  <= cows;
            end
            if (win_j1) begin
                winner <= WIN_J1;
                if (J1_points != 8'hFF) J1_points <= J1_points + 8'd1;
            end
            if (win_j2) begin
                winner <= WIN_J2;
                if (J2_points != 8'hFF) J2_points <= J2_points + 8'd1;
            end
            if (draw) winner <= WIN_DRAW;
            if (bump) round <= round + 8'd1;
            if (clear) begin
                bull_count <= '0;
                cow_count  <= '0;
                round      <= '0;
                winner     <= WIN_NONE;
            end
        end
    end
endmodule

// File: tb/tb_bullcow_engine.sv
// tb_bullcow_engine: directed plus randomized game sequences checked against a rule-level reference model.
module tb_bullcow_engine;
    localparam int D = 4;
    localparam int W = 4;
    localparam int BASE = 10;
    localparam int MR = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] SW = '0;
    logic [2:0]  game_state;
    logic [2:0]  bull_count, cow_count;
    logic        result_valid, input_error;
    logic [7:0]  round, J1_points, J2_points;
    logic [1:0]  winner;

    int checks = 0;
    int errors = 0;
    int m_state = 0, m_round = 0, m_win = 0, m_b = 0, m_c = 0, m_p1 = 0, m_p2 = 0;
    logic [15:0] m_s1 = '0, m_s2 = '0;

    bullcow_engine #(.DIGITS(D), .DIGIT_W(W), .BASE(BASE), .MAX_ROUNDS(MR)) dut (
        .clock(clock), .reset_n(reset_n), .enter(enter), .SW(SW),
        .game_state(game_state), .bull_count(bull_count), .cow_count(cow_count),
        .result_valid(result_valid), .input_error(input_error), .round(round),
        .winner(winner), .J1_points(J1_points), .J2_points(J2_points)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit rv, input bit er);
        chk("game_state", 32'(game_state), 32'(m_state));
        chk("bull_count", 32'(bull_count), 32'(m_b));
        chk("cow_count", 32'(cow_count), 32'(m_c));
        chk("result_valid", 32'(result_valid), 32'(rv));
        chk("input_error", 32'(input_error), 32'(er));
        chk("round", 32'(round), 32'(m_round));
        chk("winner", 32'(winner), 32'(m_win));
        chk("J1_points", 32'(J1_points), 32'(m_p1));
        chk("J2_points", 32'(J2_points), 32'(m_p2));
    endtask

    function automatic bit is_valid(input logic [15:0] v);
        int cnt[16] = '{default: 0};
        for (int i = 0; i < D; i++) begin
            if (int'(v[i*W +: W]) >= BASE) return 1'b0;
            cnt[v[i*W +: W]]++;
        end
`ifndef BULLCOW_REPEAT_DIGITS_EN
        for (int k = 0; k < 16; k++) if (cnt[k] > 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Bulls are equal positions; cows are the per-value overlap of the leftover digits.
    function automatic void score(input logic [15:0] g, input logic [15:0] s, output int b, output int c);
        int cg[16] = '{default: 0};
        int cs[16] = '{default: 0};
        b = 0;
        c = 0;
        for (int i = 0; i < D; i++) begin
            if (g[i*W +: W] == s[i*W +: W]) b++;
            else begin
                cg[g[i*W +: W]]++;
                cs[s[i*W +: W]]++;
            end
        end
        for (int k = 0; k < 16; k++) c += (cg[k] < cs[k]) ? cg[k] : cs[k];
    endfunction

    task automatic model_press(input logic [15:0] v, output bit rv, output bit er);
        bit ok;
        int b, c;
        ok = is_valid(v);
        rv = 1'b0;
        er = 1'b0;
        case (m_state)
            0: if (ok) begin m_s1 = v; m_state = 1; end else er = 1'b1;
            1: if (ok) begin m_s2 = v; m_round = 1; m_state = 2; end else er = 1'b1;
            2, 3: if (!ok) er = 1'b1;
                  else begin
                      score(v, m_state == 2 ? m_s2 : m_s1, b, c);
                      rv = 1'b1;
                      m_b = b;
                      m_c = c;
                      if (b == D) begin
                          if (m_state == 2) begin m_win = 1; if (m_p1 < 255) m_p1++; end
                          else begin m_win = 2; if (m_p2 < 255) m_p2++; end
                          m_state = 7;
                      end else if (m_state == 2) m_state = 3;
                      else if (m_round == MR) begin m_win = 3; m_state = 7; end
                      else begin m_round++; m_state = 2; end
                  end
            default: begin m_state = 0; m_b = 0; m_c = 0; m_round = 0; m_win = 0; end
        endcase
    endtask

    task automatic do_press(input logic [15:0] v);
        bit rv, er;
        model_press(v, rv, er);
        SW = v;
        enter = 1'b1;
        @(posedge clock); #1;
        check_all(rv, er);
        enter = 1'b0;
        @(posedge clock); #1;
        check_all(1'b0, 1'b0);
    endtask

    function automatic logic [15:0] rand_distinct();
        logic [15:0] v = '0;
        bit taken[10] = '{default: 1'b0};
        int d;
        for (int i = 0; i < D; i++) begin
            do d = $urandom_range(9); while (taken[d]);
            taken[d] = 1'b1;
            v[i*W +: W] = 4'(d);
        end
        return v;
    endfunction

    function automatic logic [15:0] rand_miss(input logic [15:0] s);
        logic [15:0] v;
        do v = rand_distinct(); while (v == s);
        return v;
    endfunction

    task automatic to_setup();
        for (int n = 0; n < 8 && m_state != 0; n++) begin
            case (m_state)
                2: do_press(m_s2);
                3: do_press(m_s1);
                default: do_press(rand_distinct());
            endcase
        end
        chk("to_setup", 32'(game_state), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_all(1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_press(16'h1234);
        do_press(16'h5678);
        do_press(16'h5678);
        do_press(16'h0000);

        do_press(16'h1234);
        do_press(16'h5678);
        do_press(16'h8765);
        do_press(16'h4321);
        do_press(16'h5687);
        do_press(16'h9012);
        do_press(16'h0001);

        do_press(16'h12A4);
        SW = 16'h1234;
        enter = 1'b1;
        m_s1 = SW;
        m_state = 1;
        @(posedge clock); #1;
        check_all(1'b0, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        check_all(1'b0, 1'b0);
        enter = 1'b0;
        @(posedge clock); #1;
        do_press(16'h1123);
        if (m_state == 2) do_press(16'h3111);
        to_setup();

        do_press(16'h1234);
        do_press(16'h5678);
        do_press(16'h9012);
        do_press(16'h9087);
        do_press(16'h9013);
        do_press(16'h1234);

        to_setup();
        while (m_p1 < 256 && J1_points != 8'hFF && m_p1 != 255) begin
            do_press(rand_distinct());
            do_press(rand_distinct());
            do_press(m_s2);
            do_press(16'h0000);
        end
        do_press(rand_distinct());
        do_press(rand_distinct());
        do_press(m_s2);
        do_press(16'h0000);

        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(99);
            if (r < 15) do_press(16'($urandom));
            else if (r < 35 && m_state == 2) do_press(m_s2);
            else if (r < 45 && m_state == 3) do_press(m_s1);
            else do_press(rand_distinct());
        end

        to_setup();
        do_press(rand_distinct());
        do_press(rand_distinct());
        do_press(rand_miss(m_s2));
        chk("pre_reset_state", 32'(game_state), 32'd3);
        reset_n = 1'b0;
        #2;
        m_state = 0; m_round = 0; m_win = 0; m_b = 0; m_c = 0; m_p1 = 0; m_p2 = 0;
        m_s1 = '0; m_s2 = '0;
        @(posedge clock); #1;
        check_all(1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_press(16'h0123);
        do_press(16'h4567);
        do_press(16'h4567);
        check_all(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
